// File: rtl/fir_spi_pkg.sv
// Shared types and defaults for the FIR-SPI sample path.
package fir_spi_pkg;

    localparam int SPI_WORD_BITS = 16;
    localparam int FRAME_SAMPLES = 1000;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        HOLD
    } tx_state_t;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with sync clear and programmable wrap value; wraps to 0 after rollover_val.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            count_out <= '0;
        else if (clear)
            count_out <= '0;
        else if (count_enable)
            count_out <= (count_out == rollover_val) ? '0 : count_out + NUM_CNT_BITS'(1);
    end

endmodule

// File: rtl/spi_tx_shifter.sv
// Parallel-load, MSB-first shift register; load wins over shift.
module spi_tx_shifter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  load,
    input  logic                  shift_enable,
    input  logic [DATA_WIDTH-1:0] par_in,
    output logic                  msb
);

    logic [DATA_WIDTH-1:0] shreg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            shreg <= '0;
        else if (load)
            shreg <= par_in;
        else if (shift_enable)
            shreg <= shreg << 1;
    end

    assign msb = shreg[DATA_WIDTH-1];

endmodule

// File: rtl/spi_result_tx.sv
// SPI mode-0 master that serialises FIR result words and counts them into frames.
module spi_result_tx
    import fir_spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_WORD_BITS,
    parameter int CLK_DIV     = 4,
    parameter int NUM_SAMPLES = FRAME_SAMPLES,
    parameter int CNT_BITS    = 10
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  sck,
    output logic                  mosi,
    output logic                  ss_n,
    output logic                  busy,
    output logic                  frame_done,
    output logic [CNT_BITS-1:0]   sample_cnt
);

    localparam int PH_BITS  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_BITS = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PH_BITS-1:0]  PH_LAST  = PH_BITS'(CLK_DIV - 1);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(NUM_SAMPLES - 1);

    tx_state_t           state, state_next;
    logic [PH_BITS-1:0]  phase;
    logic [IDX_BITS-1:0] bit_idx;
    logic                phase_done, last_bit, load, shift_en, word_done, msb;

    assign tx_ready   = (state == IDLE) && !clear;
    assign load       = tx_valid && tx_ready;
    assign phase_done = (state != IDLE) && (phase == PH_LAST);
    assign last_bit   = (bit_idx == '0);
    // Shift as the rising edge is issued so msb already holds the next bit
    // by the time the falling edge needs it.
    assign shift_en   = (state == SHIFT_LO) && phase_done && !clear;
    assign word_done  = (state == HOLD) && phase_done && !clear;
    assign busy       = !ss_n;

    spi_tx_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_shifter (
        .clk          (clk),
        .n_rst        (n_rst),
        .load         (load),
        .shift_enable (shift_en),
        .par_in       (tx_data),
        .msb          (msb)
    );

    flex_counter #(.NUM_CNT_BITS(PH_BITS)) u_phase_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear || (state_next != state)),
        .count_enable (state != IDLE),
        .rollover_val (PH_LAST),
        .count_out    (phase)
    );

    flex_counter #(.NUM_CNT_BITS(CNT_BITS)) u_sample_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .count_enable (word_done),
        .rollover_val (CNT_LAST),
        .count_out    (sample_cnt)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (load)       state_next = SHIFT_LO;
            SHIFT_LO: if (phase_done) state_next = SHIFT_HI;
            SHIFT_HI: if (phase_done) state_next = last_bit ? HOLD : SHIFT_LO;
            HOLD:     if (phase_done) state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
        if (clear)
            state_next = IDLE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            bit_idx <= '0;
        else if (load)
            bit_idx <= IDX_BITS'(DATA_WIDTH - 1);
        else if ((state == SHIFT_HI) && phase_done && !last_bit)
            bit_idx <= bit_idx - IDX_BITS'(1);
    end

    // Link outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ss_n       <= 1'b1;
            sck        <= 1'b0;
            mosi       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            ss_n       <= (state_next == IDLE);
            sck        <= (state_next == SHIFT_HI);
            frame_done <= word_done && (sample_cnt == CNT_LAST);
            if (state_next == IDLE)
                mosi <= 1'b0;
            else if (load)
                mosi <= tx_data[DATA_WIDTH-1];
            else if ((state == SHIFT_HI) && (state_next == SHIFT_LO))
                mosi <= msb;
        end
    end

endmodule

// File: tb/tb_spi_result_tx.sv
// Bench for spi_result_tx: CLK_DIV=4/4-word frames on dut_a, CLK_DIV=1/1000-word frames on dut_b.
module tb_spi_result_tx;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic [1:0]  clear, tx_valid, tx_ready, sck, mosi, ss_n, busy, frame_done;
    logic [15:0] tx_data [2];
    logic [9:0]  sample_cnt [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_result_tx #(.DATA_WIDTH(16), .CLK_DIV(4), .NUM_SAMPLES(4), .CNT_BITS(10)) dut_a (
        .clk(clk), .n_rst(n_rst), .clear(clear[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .sck(sck[0]), .mosi(mosi[0]), .ss_n(ss_n[0]), .busy(busy[0]),
        .frame_done(frame_done[0]), .sample_cnt(sample_cnt[0])
    );

    spi_result_tx #(.CLK_DIV(1)) dut_b (
        .clk(clk), .n_rst(n_rst), .clear(clear[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .sck(sck[1]), .mosi(mosi[1]), .ss_n(ss_n[1]), .busy(busy[1]),
        .frame_done(frame_done[1]), .sample_cnt(sample_cnt[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d (0x%0h) expected %0d (0x%0h) at t=%0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Serial-side monitor: rebuilds each word from mosi at sck rising edges.
    logic [15:0] rx_word [2];
    int          bitcnt [2] = '{0, 0};
    int          lowcnt [2] = '{0, 0};
    int          fd_cnt [2] = '{0, 0};
    int          exp_low [2] = '{132, 33};
    int          idle_bad = 0;
    int          fd_wide = 0;
    logic [1:0]  prev_sck = 2'b00, prev_ss = 2'b11, prev_fd = 2'b00, abort = 2'b00;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [15:0] e;
            if (!ss_n[k]) lowcnt[k]++;
            if (sck[k] && !prev_sck[k]) begin
                rx_word[k] = {rx_word[k][14:0], mosi[k]};
                bitcnt[k]++;
            end
            if (ss_n[k] && (mosi[k] || sck[k] || busy[k])) idle_bad++;
            if (!ss_n[k] && (tx_ready[k] || !busy[k])) idle_bad++;
            if (frame_done[k]) fd_cnt[k]++;
            if (frame_done[k] && prev_fd[k]) fd_wide++;
            if (ss_n[k] && !prev_ss[k]) begin
                if ((k == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0)) begin
                    chk("sb_unexpected_word", 1, 0);
                end else begin
                    e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    if (abort[k]) begin
                        abort[k] = 1'b0;
                    end else begin
                        chk(k == 0 ? "word_a" : "word_b", int'(rx_word[k]), int'(e));
                        chk(k == 0 ? "ss_low_a" : "ss_low_b", lowcnt[k], exp_low[k]);
                        chk(k == 0 ? "bits_a" : "bits_b", bitcnt[k], 16);
                    end
                end
                lowcnt[k] = 0;
                bitcnt[k] = 0;
            end
            prev_sck[k] = sck[k];
            prev_ss[k]  = ss_n[k];
            prev_fd[k]  = frame_done[k];
        end
    end

    task automatic send(input int k, input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        tx_data[k]  = d;
        tx_valid[k] = 1'b1;
        while (!tx_ready[k] && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready[k]) chk("hs_timeout", 0, 1);
        else if (k == 0) exp_q0.push_back(d);
        else exp_q1.push_back(d);
        @(posedge clk);
        #1 tx_valid[k] = 1'b0;
    endtask

    // Returns at the negedge of the first idle cycle after a word.
    task automatic wait_done(input int k);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ss_n[k] && n < 400);
        if (!ss_n[k]) chk("done_timeout", 0, 1);
    endtask

    typedef struct {
        logic [15:0] data;
        int          cnt;
        logic        fd;
    } vec_t;
    vec_t vecs [6];

    task automatic chk_reset_a(input string tag);
        chk({tag, "_ss_n"}, ss_n[0], 1);
        chk({tag, "_sck"}, sck[0], 0);
        chk({tag, "_mosi"}, mosi[0], 0);
        chk({tag, "_busy"}, busy[0], 0);
        chk({tag, "_fd"}, frame_done[0], 0);
        chk({tag, "_cnt"}, sample_cnt[0], 0);
        chk({tag, "_rdy"}, tx_ready[0], 1);
    endtask

    initial begin
        int t1, t2, n, r;
        logic pss, ps;
        vecs[0] = '{16'hA5C3, 1, 1'b0};
        vecs[1] = '{16'h0001, 2, 1'b0};
        vecs[2] = '{16'h8000, 3, 1'b0};
        vecs[3] = '{16'h1234, 0, 1'b1};
        vecs[4] = '{16'h5A5A, 1, 1'b0};
        vecs[5] = '{16'h0F0F, 2, 1'b0};
        clear = '0;
        tx_valid = '0;
        tx_data[0] = '0;
        tx_data[1] = '0;

        #1 n_rst = 1'b0;
        #2 chk_reset_a("rst0");
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        // Table: each word's completion count and frame pulse (4-word frames).
        for (int i = 0; i < 6; i++) begin
            send(0, vecs[i].data);
            wait_done(0);
            chk("tbl_cnt", sample_cnt[0], vecs[i].cnt);
            chk("tbl_fd", frame_done[0], vecs[i].fd);
            @(negedge clk);
            chk("tbl_fd_off", frame_done[0], 0);
        end

        // Back-to-back with tx_valid held; tx_data changed mid-word.
        @(negedge clk);
        tx_data[0]  = 16'h0001;
        tx_valid[0] = 1'b1;
        chk("b2b_rdy", tx_ready[0], 1);
        t1 = cyc;
        exp_q0.push_back(16'h0001);
        @(posedge clk);
        #1 tx_data[0] = 16'h8000;
        n = 0;
        do begin
            pss = ss_n[0];
            @(negedge clk);
            n++;
        end while (!tx_ready[0] && n < 400);
        t2 = cyc;
        chk("b2b_gap", t2 - t1, 133);
        chk("b2b_prev_ss", pss, 0);
        chk("b2b_ss_hi", ss_n[0], 1);
        if (tx_ready[0]) exp_q0.push_back(16'h8000);
        @(posedge clk);
        #1 tx_data[0] = 16'h7777;
        tx_valid[0] = 1'b0;
        @(negedge clk);
        chk("b2b_ss_lo_again", ss_n[0], 0);
        wait_done(0);
        chk("b2b_cnt", sample_cnt[0], 0);
        chk("b2b_fd", frame_done[0], 1);

        // clear mid-word after 5 bits.
        send(0, 16'h3C3C);
        wait_done(0);
        chk("pre_clr_cnt", sample_cnt[0], 1);
        send(0, 16'hFFFF);
        r = 0;
        n = 0;
        ps = sck[0];
        while (r < 5 && n < 200) begin
            @(negedge clk);
            if (sck[0] && !ps) r++;
            ps = sck[0];
            n++;
        end
        chk("pre_clr_bits", r, 5);
        abort[0] = 1'b1;
        clear[0] = 1'b1;
        #1 chk("clr_rdy", tx_ready[0], 0);
        @(posedge clk);
        #1 clear[0] = 1'b0;
        #1 chk_reset_a("clr");
        // clear while idle suppresses the handshake.
        @(negedge clk);
        clear[0] = 1'b1;
        tx_valid[0] = 1'b1;
        tx_data[0] = 16'hBEEF;
        @(posedge clk);
        #1 clear[0] = 1'b0;
        tx_valid[0] = 1'b0;
        chk("clr_no_hs", ss_n[0], 1);
        send(0, 16'h1234);
        wait_done(0);
        chk("post_clr_cnt", sample_cnt[0], 1);

        // Async reset mid-word, between edges.
        send(0, 16'hA5C3);
        repeat (20) @(negedge clk);
        abort[0] = 1'b1;
        @(posedge clk);
        #3 n_rst = 1'b0;
        #1 chk_reset_a("rst_mid");
        @(negedge clk);
        n_rst = 1'b1;

        // CLK_DIV=1, then a full 1000-word frame.
        send(1, 16'h8001);
        wait_done(1);
        chk("b_cnt_first", sample_cnt[1], 1);
        for (int i = 1; i < 999; i++) begin
            send(1, 16'($urandom));
            wait_done(1);
            chk("b_cnt", sample_cnt[1], i + 1);
        end
        chk("b_no_early_fd", fd_cnt[1], 0);
        send(1, 16'hC0DE);
        wait_done(1);
        chk("b_wrap_cnt", sample_cnt[1], 0);
        chk("b_fd", frame_done[1], 1);
        @(negedge clk);
        chk("b_fd_off", frame_done[1], 0);

        repeat (3) @(negedge clk);
        chk("idle_violations", idle_bad, 0);
        chk("fd_wide", fd_wide, 0);
        chk("fd_cnt_a", fd_cnt[0], 2);
        chk("fd_cnt_b", fd_cnt[1], 1);
        chk("sb_leftover", exp_q0.size() + exp_q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_result_tx.md
Name: spi_result_tx

Overview:
- Transmit end of the FIR-SPI sample path. Takes filtered result words from the FIR datapath over a valid/ready handshake and serialises each one onto an SPI mode-0 link (this block is the master).
- Counts the words it sends and pulses frame_done once per NUM_SAMPLES-word frame. This mirrors the receive-side 1k sample counter.

Parameters:
DATA_WIDTH, 16, bits per SPI word, sent MSB first
CLK_DIV, 4, clk cycles per SCK half-period (>=1)
NUM_SAMPLES, 1000, words per frame
CNT_BITS, 10, width of sample_cnt (2**CNT_BITS >= NUM_SAMPLES)

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
clear  in  1  synchronous abort; resets the frame count
tx_data  in  DATA_WIDTH  result word to send
tx_valid  in  1  tx_data is valid
tx_ready  out  1  block can accept a word
sck  out  1  SPI clock, idles low
mosi  out  1  SPI serial data
ss_n  out  1  SPI slave select, active low
busy  out  1  a word is in flight (ss_n low)
frame_done  out  1  one-cycle pulse after word NUM_SAMPLES of a frame completes
sample_cnt  out  CNT_BITS  words completed in the current frame

Behaviour:
Interface constraint (already decided): one clock, clk; reset n_rst is asynchronous and active-low.

Reset (async, immediate, no clock edge needed):
- sck=0, mosi=0, ss_n=1, busy=0, frame_done=0, sample_cnt=0, tx_ready=1.
- FSM goes to IDLE.

FSM states: IDLE, SHIFT_LO, SHIFT_HI, HOLD.

IDLE:
- tx_ready = !clear.
- Handshake is tx_valid && tx_ready at cycle T0. On it, capture tx_data into the shift register and load bit index DATA_WIDTH-1. Next state SHIFT_LO.

SHIFT_LO:
- ss_n=0, sck=0, mosi=current bit, held for CLK_DIV cycles, then SHIFT_HI.

SHIFT_HI:
- sck=1 for CLK_DIV cycles. The receiver samples on the rising edge.
- If this is not the last bit: decrement the index, go to SHIFT_LO. mosi changes on the falling edge.
- After bit 0: go to HOLD.

HOLD:
- sck=0, ss_n=0, held for CLK_DIV cycles, then IDLE.
- On the exit edge, the word counts as complete.

Outputs and timing:
- sck, mosi, ss_n and frame_done are registered.
- ss_n falls at T0+1 and stays low (2*DATA_WIDTH+1)*CLK_DIV cycles: 132 at defaults.
- ss_n rises at T0+1+132. tx_ready is 1 in that same cycle, so the earliest next handshake is at T0+133.
- ss_n is high for at least 1 cycle between words.
- busy = !ss_n.
- mosi = 0 whenever ss_n=1.
- Changes on tx_data or tx_valid while not in IDLE are ignored. The captured word is immutable.

Counting:
- On word completion, sample_cnt increments.
- If the completed word is number NUM_SAMPLES (sample_cnt == NUM_SAMPLES-1): sample_cnt wraps to 0, and frame_done is 1 for exactly the first IDLE cycle.

clear (synchronous, highest priority):
- Next cycle: FSM in IDLE, ss_n=1, sck=0, mosi=0, sample_cnt=0, frame_done=0.
- A partial word is discarded and not counted.
- A handshake in the same cycle as clear does not occur (tx_ready=0).

Phase counter: ceil(log2(CLK_DIV)) bits, reloaded on every state change.

Decomposition:
- Package fir_spi_pkg holds: state enum tx_state_t (IDLE, SHIFT_LO, SHIFT_HI, HOLD), and constants SPI_WORD_BITS=16 and FRAME_SAMPLES=1000 used as parameter defaults.
- One sub-module, spi_tx_shifter: a DATA_WIDTH parallel-load, MSB-first shift register with load and shift_enable, exposing msb.
- Phase and sample counting reuse the codebase's flex_counter; no further sub-modules.

Test Plan (CLK_DIV=4 unless noted):
1. Reset: assert n_rst=0 mid-simulation between edges -> all outputs at their reset values immediately; tx_ready=1.
2. Single word 16'hA5C3 -> ss_n low 132 cycles; mosi sampled at the 16 sck rising edges reads 1010_0101_1100_0011; tx_ready=0 throughout; sample_cnt=1 afterwards.
3. tx_valid held high with words 16'h0001 then 16'h8000 -> second handshake exactly 133 cycles after the first; ss_n high exactly 1 cycle between words; tx_data altered mid-word has no effect on mosi.
4. Frame with NUM_SAMPLES=4 and also with the default 1000 -> frame_done pulses once, 1 cycle wide, as the 4th/1000th word ends; sample_cnt goes 3->0 (999->0); no pulse on other words.
5. clear after 5 bits of 16'hFFFF -> next cycle ss_n=1, sck=0, mosi=0, sample_cnt=0, tx_ready=1, no frame_done. A following word 16'h1234 shifts out intact.
6. CLK_DIV=1 with word 16'h8001 -> sck half-period 1 cycle; ss_n low 33 cycles; bit stream is 1, fourteen 0s, then 1.
